// File: rtl/boron_pkg.sv
// Shared constants, S-box helpers and FSM state type for the BORON key schedule.
// The inverse S-box and PRECALC state exist only with BORON_KS_REVERSE_EN defined.
package boron_pkg;

  localparam int BORON_KEY_W  = 80;
  localparam int BORON_BLK_W  = 64;
  localparam int BORON_ROUNDS = 25;
  localparam int BORON_ROT    = 13;
  localparam int BORON_RND_W  = 5;

  localparam logic [BORON_RND_W-1:0] BORON_LAST_RND = 5'd25;

  typedef enum logic [1:0] {
    S_IDLE,
`ifdef BORON_KS_REVERSE_EN
    S_PRECALC,
`endif
    S_EMIT
  } ks_state_t;

  function automatic logic [3:0] s_box(input logic [3:0] x);
    case (x)
      4'h0: s_box = 4'hE;  4'h1: s_box = 4'h4;  4'h2: s_box = 4'hB;  4'h3: s_box = 4'h1;
      4'h4: s_box = 4'h7;  4'h5: s_box = 4'h9;  4'h6: s_box = 4'hC;  4'h7: s_box = 4'hA;
      4'h8: s_box = 4'hD;  4'h9: s_box = 4'h2;  4'hA: s_box = 4'h0;  4'hB: s_box = 4'hF;
      4'hC: s_box = 4'h8;  4'hD: s_box = 4'h5;  4'hE: s_box = 4'h3;  default: s_box = 4'h6;
    endcase
  endfunction

`ifdef BORON_KS_REVERSE_EN
  function automatic logic [3:0] dec_s_box(input logic [3:0] x);
    case (x)
      4'h0: dec_s_box = 4'hA;  4'h1: dec_s_box = 4'h3;  4'h2: dec_s_box = 4'h9;  4'h3: dec_s_box = 4'hE;
      4'h4: dec_s_box = 4'h1;  4'h5: dec_s_box = 4'hD;  4'h6: dec_s_box = 4'hF;  4'h7: dec_s_box = 4'h4;
      4'h8: dec_s_box = 4'hC;  4'h9: dec_s_box = 4'h5;  4'hA: dec_s_box = 4'h7;  4'hB: dec_s_box = 4'h2;
      4'hC: dec_s_box = 4'h6;  4'hD: dec_s_box = 4'h8;  4'hE: dec_s_box = 4'h0;  default: dec_s_box = 4'hB;
    endcase
  endfunction
`endif

endpackage

// File: rtl/boron_key_schedule_if.sv
// Start/key request and round-key stream handshake of the BORON key schedule.
// i_ks_dir is present only with BORON_KS_REVERSE_EN defined.
interface boron_key_schedule_if;

  logic                            i_ks_start;
  logic [boron_pkg::BORON_KEY_W-1:0] i_ks_key;
`ifdef BORON_KS_REVERSE_EN
  logic                            i_ks_dir;
`endif
  logic                            i_ks_ready;
  logic [boron_pkg::BORON_BLK_W-1:0] o_ks_rkey;
  logic [boron_pkg::BORON_RND_W-1:0] o_ks_round;
  logic                            o_ks_valid;
  logic                            o_ks_busy;
  logic                            o_ks_done;

  modport slave (
    input  i_ks_start, i_ks_key,
`ifdef BORON_KS_REVERSE_EN
    input  i_ks_dir,
`endif
    input  i_ks_ready,
    output o_ks_rkey, o_ks_round, o_ks_valid, o_ks_busy, o_ks_done
  );

  modport master (
    output i_ks_start, i_ks_key,
`ifdef BORON_KS_REVERSE_EN
    output i_ks_dir,
`endif
    output i_ks_ready,
    input  o_ks_rkey, o_ks_round, o_ks_valid, o_ks_busy, o_ks_done
  );

endinterface

// File: rtl/boron_ks_step.sv
// Combinational single BORON key-schedule step (forward, or inverse when
// BORON_KS_REVERSE_EN is defined and i_dir is high).
module boron_ks_step
  import boron_pkg::*;
(
  input  logic [BORON_KEY_W-1:0] i_key,
  input  logic [BORON_RND_W-1:0] i_rc,
`ifdef BORON_KS_REVERSE_EN
  input  logic                   i_dir,
`endif
  output logic [BORON_KEY_W-1:0] o_key
);

  logic [BORON_KEY_W-1:0] w_fwd;

  always_comb begin
    w_fwd        = {i_key[BORON_KEY_W-BORON_ROT-1:0], i_key[BORON_KEY_W-1:BORON_KEY_W-BORON_ROT]};
    w_fwd[3:0]   = s_box(w_fwd[3:0]);
    w_fwd[63:59] = w_fwd[63:59] ^ i_rc;
  end

`ifdef BORON_KS_REVERSE_EN
  // Inverse undoes the forward step in the opposite order: RC, S-box, rotation.
  logic [BORON_KEY_W-1:0] w_mix;
  logic [BORON_KEY_W-1:0] w_inv;

  always_comb begin
    w_mix        = i_key;
    w_mix[63:59] = w_mix[63:59] ^ i_rc;
    w_mix[3:0]   = dec_s_box(w_mix[3:0]);
    w_inv        = {w_mix[BORON_ROT-1:0], w_mix[BORON_KEY_W-1:BORON_ROT]};
  end

  assign o_key = i_dir ? w_inv : w_fwd;
`else
  assign o_key = w_fwd;
`endif

endmodule

// File: rtl/boron_key_schedule.sv
// BORON key schedule: streams round keys 0..25 per accepted handshake.
// Reverse order (via PRECALC) is compiled in with BORON_KS_REVERSE_EN.
module boron_key_schedule
  import boron_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  boron_key_schedule_if.slave  ks
);

  ks_state_t              r_state;
  logic [BORON_KEY_W-1:0] r_key;
  logic [BORON_RND_W-1:0] r_round;
  logic                   r_valid;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_inv;
  logic                   w_fire;
  logic                   w_last;
  logic [BORON_RND_W-1:0] w_rc;
  logic [BORON_KEY_W-1:0] w_next;

`ifdef BORON_KS_REVERSE_EN
  logic r_dir;
  assign w_inv = r_dir && (r_state == S_EMIT);
`else
  assign w_inv = 1'b0;
`endif

  // Forward step producing key i+1 uses RC=i+1; inverse step from key i uses RC=i.
  assign w_rc   = w_inv ? r_round : (r_round + 5'd1);
  assign w_fire = r_valid && ks.i_ks_ready;
  assign w_last = w_inv ? (r_round == 5'd0) : (r_round == BORON_LAST_RND);

  boron_ks_step u_step (
    .i_key (r_key),
    .i_rc  (w_rc),
`ifdef BORON_KS_REVERSE_EN
    .i_dir (w_inv),
`endif
    .o_key (w_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_key   <= '0;
      r_round <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef BORON_KS_REVERSE_EN
      r_dir   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ks.i_ks_start) begin
            r_key   <= ks.i_ks_key;
            r_round <= '0;
            r_busy  <= 1'b1;
`ifdef BORON_KS_REVERSE_EN
            r_dir   <= ks.i_ks_dir;
            if (ks.i_ks_dir) begin
              r_state <= S_PRECALC;
              r_valid <= 1'b0;
            end else begin
              r_state <= S_EMIT;
              r_valid <= 1'b1;
            end
`else
            r_state <= S_EMIT;
            r_valid <= 1'b1;
`endif
          end
        end
`ifdef BORON_KS_REVERSE_EN
        // r_round doubles as the precalc step counter and lands on 25.
        S_PRECALC: begin
          r_key   <= w_next;
          r_round <= r_round + 5'd1;
          if (r_round == BORON_LAST_RND - 5'd1) begin
            r_state <= S_EMIT;
            r_valid <= 1'b1;
          end
        end
`endif
        S_EMIT: begin
          if (w_fire) begin
            if (w_last) begin
              r_state <= S_IDLE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_key   <= w_next;
              r_round <= w_inv ? (r_round - 5'd1) : (r_round + 5'd1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ks.o_ks_rkey  = r_key[BORON_BLK_W-1:0];
  assign ks.o_ks_round = r_round;
  assign ks.o_ks_valid = r_valid;
  assign ks.o_ks_busy  = r_busy;
  assign ks.o_ks_done  = r_done;

endmodule

// File: tb/tb_boron_key_schedule.sv
// Self-checking bench for boron_key_schedule; reverse-order runs are exercised
// only when BORON_KS_REVERSE_EN is defined.
module tb_boron_key_schedule;

  typedef struct packed {
    logic [63:0] key;
    logic [4:0]  rnd;
  } expT;

  logic clk = 1'b0;
  logic rst = 1'b1;

  boron_key_schedule_if ks();

  boron_key_schedule dut (
    .clk (clk),
    .rst (rst),
    .ks  (ks)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  expT         expQ[$];
  logic [63:0] refK[26];
  logic [63:0] obsKeys[26];
  logic [63:0] sboxTab = 64'h6358_F02D_AC97_1B4E;

  // Reference model: 160-bit doubled shift gives the 80-bit left rotation.
  function automatic logic [79:0] refStep(input logic [79:0] k, input logic [4:0] rc);
    logic [159:0] d;
    logic [79:0]  n;
    d = {k, k} << 13;
    n = d[159:80];
    n[3:0] = sboxTab[{n[3:0], 2'b00} +: 4];
    n[63:59] = n[63:59] ^ rc;
    return n;
  endfunction

  task automatic computeRef(input logic [79:0] master);
    logic [79:0] k;
    k = master;
    refK[0] = k[63:0];
    for (int i = 1; i <= 25; i++) begin
      k = refStep(k, 5'(i));
      refK[i] = k[63:0];
    end
  endtask

  task automatic checkOutput(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one start request, queues the expected key stream and checks first-key latency.
  task automatic applyStimulus(input logic [79:0] master, input bit dir, input string tag);
    computeRef(master);
    for (int i = 0; i <= 25; i++) begin
      if (dir) expQ.push_back('{key: refK[25-i], rnd: 5'(25-i)});
      else     expQ.push_back('{key: refK[i],    rnd: 5'(i)});
    end
    ks.i_ks_start = 1'b1;
    ks.i_ks_key   = master;
`ifdef BORON_KS_REVERSE_EN
    ks.i_ks_dir   = dir;
`endif
    tick();
    ks.i_ks_start = 1'b0;
    ks.i_ks_key   = {$urandom, $urandom, $urandom};
`ifdef BORON_KS_REVERSE_EN
    ks.i_ks_dir   = ~dir;
`endif
    if (dir) begin
      for (int i = 0; i < 25; i++) begin
        checkOutput({tag, "_precalc_valid"}, ks.o_ks_valid, 1'b0);
        tick();
      end
    end
    checkOutput({tag, "_first_valid"}, ks.o_ks_valid, 1'b1);
    checkOutput({tag, "_first_round"}, ks.o_ks_round, dir ? 5'd25 : 5'd0);
    checkOutput({tag, "_first_busy"},  ks.o_ks_busy,  1'b1);
  endtask

  task automatic consumeRun(input bit randomReady, input bit busyStart, input string tag);
    int          cycles = 0;
    bit          finished = 0;
    bit          prevStall = 0;
    logic [63:0] heldKey = '0;
    logic [4:0]  heldRound = '0;
    expT         e;
    while (!finished && cycles < 400) begin
      if (prevStall) begin
        checkOutput({tag, "_hold_key"},   ks.o_ks_rkey,  heldKey);
        checkOutput({tag, "_hold_round"}, ks.o_ks_round, heldRound);
        checkOutput({tag, "_hold_valid"}, ks.o_ks_valid, 1'b1);
      end
      checkOutput({tag, "_no_early_done"}, ks.o_ks_done, 1'b0);
      ks.i_ks_start = (busyStart && cycles == 3);
      if (busyStart && cycles == 3) ks.i_ks_key = {$urandom, $urandom, $urandom};
      ks.i_ks_ready = randomReady ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (ks.o_ks_valid && ks.i_ks_ready) begin
        if (expQ.size() == 0) begin
          checkOutput({tag, "_unexpected_key"}, 1'b1, 1'b0);
          finished = 1;
        end else begin
          e = expQ.pop_front();
          checkOutput({tag, "_rkey"},  ks.o_ks_rkey,  e.key);
          checkOutput({tag, "_round"}, ks.o_ks_round, e.rnd);
          if (ks.o_ks_round <= 5'd25) obsKeys[ks.o_ks_round] = ks.o_ks_rkey;
          if (expQ.size() == 0) finished = 1;
        end
      end
      prevStall = ks.o_ks_valid && !ks.i_ks_ready;
      heldKey   = ks.o_ks_rkey;
      heldRound = ks.o_ks_round;
      tick();
      ks.i_ks_start = 1'b0;
      cycles++;
    end
    ks.i_ks_ready = 1'b1;
    if (!finished) begin
      checkOutput({tag, "_timeout"}, 1'b0, 1'b1);
    end else begin
      checkOutput({tag, "_done_pulse"}, ks.o_ks_done,  1'b1);
      checkOutput({tag, "_done_valid"}, ks.o_ks_valid, 1'b0);
      checkOutput({tag, "_done_busy"},  ks.o_ks_busy,  1'b0);
    end
  endtask

  initial begin
    logic [63:0] pt;
    logic [63:0] ct;
    ks.i_ks_start = 1'b0;
    ks.i_ks_key   = '0;
    ks.i_ks_ready = 1'b1;
`ifdef BORON_KS_REVERSE_EN
    ks.i_ks_dir   = 1'b0;
`endif

    rst = 1'b1;
    tick();
    tick();
    checkOutput("reset_rkey",  ks.o_ks_rkey,  64'h0);
    checkOutput("reset_round", ks.o_ks_round, 5'd0);
    checkOutput("reset_valid", ks.o_ks_valid, 1'b0);
    checkOutput("reset_busy",  ks.o_ks_busy,  1'b0);
    checkOutput("reset_done",  ks.o_ks_done,  1'b0);
    rst = 1'b0;
    tick();

    $display("[TB] forward run from zero key");
    applyStimulus(80'h0, 1'b0, "fwd0");
    consumeRun(1'b0, 1'b0, "fwd0");
    checkOutput("fwd0_const_r0", obsKeys[0], 64'h0);
    checkOutput("fwd0_const_r1", obsKeys[1], 64'h0800_0000_0000_000E);

    $display("[TB] back-to-back start in done cycle, backpressure, start while busy");
    applyStimulus(80'h0, 1'b0, "bp");
    consumeRun(1'b1, 1'b1, "bp");
    checkOutput("bp_const_r1", obsKeys[1], 64'h0800_0000_0000_000E);
    tick();

`ifdef BORON_KS_REVERSE_EN
    $display("[TB] reverse run");
    applyStimulus(80'h0000_0000_0000_0000_000E, 1'b1, "rev");
    consumeRun(1'b0, 1'b0, "rev");
    checkOutput("rev_const_r0", obsKeys[0], 64'h0000_0000_0000_000E);
    tick();
    applyStimulus(80'h9A3C_55F0_0123_4567_89AB, 1'b1, "revbp");
    consumeRun(1'b1, 1'b0, "revbp");
    tick();
`endif

    $display("[TB] reset mid-run");
    applyStimulus(80'h1234_5678_9ABC_DEF0_1357, 1'b0, "rst");
    for (int i = 0; i < 10; i++) tick();
    checkOutput("rst_round10", ks.o_ks_round, 5'd10);
    checkOutput("rst_rkey10",  ks.o_ks_rkey,  refK[10]);
    expQ.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_mid_rkey",  ks.o_ks_rkey,  64'h0);
    checkOutput("rst_mid_round", ks.o_ks_round, 5'd0);
    checkOutput("rst_mid_valid", ks.o_ks_valid, 1'b0);
    checkOutput("rst_mid_busy",  ks.o_ks_busy,  1'b0);
    checkOutput("rst_mid_done",  ks.o_ks_done,  1'b0);
    tick();
    checkOutput("rst_after_done", ks.o_ks_done, 1'b0);

    applyStimulus(80'h0000_0000_0000_0000_000E, 1'b0, "replay");
    consumeRun(1'b0, 1'b0, "replay");

    pt = 64'h7777aaaa3333eeee;
    ct = pt ^ obsKeys[0];
    checkOutput("chain_cipher",    ct, 64'h7777aaaa3333eee0);
    checkOutput("chain_recovered", ct ^ obsKeys[0], 64'h7777aaaa3333eeee);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/boron_key_schedule.md
# boron_key_schedule

Sequential BORON key schedule that expands an 80-bit master key into the 26 64-bit round keys (indices 0..25) consumed by `add_round_key` and `dec_add_round_key`. It sits directly upstream of the round datapath and streams one round key per accepted handshake. Keys come out in forward order for encryption, or in reverse order for decryption when the reverse feature is compiled in.

## Interface
- No parameters; round count (25) and key widths are package constants.
- `clk` input 1: single clock, all state rising-edge.
- `rst` input 1: synchronous reset, active-high.
- `i_ks_start` input 1: start request; sampled only in IDLE.
- `i_ks_key` input 80: master key; captured on an accepted start.
- `i_ks_dir` input 1: 0 = forward, 1 = reverse. Captured with start. Present only with `BORON_KS_REVERSE_EN`.
- `i_ks_ready` input 1: consumer accepts the current key.
- `o_ks_rkey` output 64: current round key, bits [63:0] of the key register.
- `o_ks_round` output 5: index 0..25 of `o_ks_rkey`.
- `o_ks_valid` output 1: `o_ks_rkey`/`o_ks_round` are valid.
- `o_ks_busy` output 1: high in any state except IDLE.
- `o_ks_done` output 1: one-cycle pulse after the last key is accepted.

## Operation
- **Forward step, RC = i+1**, applied to the 80-bit register K to get key i+1 from key i:
  - K = K rotl 13.
  - K[3:0] = S(K[3:0]).
  - K[63:59] ^= RC.
- **Inverse step, RC = i**, to get key i-1 from key i:
  - K[63:59] ^= RC.
  - K[3:0] = S⁻¹(K[3:0]).
  - K = K rotr 13.
- **States:**
  - IDLE → EMIT on start with dir=0.
  - IDLE → PRECALC on start with dir=1.
  - PRECALC: applies forward steps RC=1..25, one per cycle (25 cycles), then → EMIT with round=25.
  - EMIT → IDLE after the last key handshake.
- **Forward EMIT:** starts at round 0 with K = master key. On valid&&ready, apply the forward step and increment round. The handshake at round 25 ends the run.
- **Reverse EMIT:** starts at round 25. On handshake, apply the inverse step and decrement round. The handshake at round 0 ends the run.
- **Ready low:** K, round, valid and rkey all hold unchanged.
- **Start while busy:** ignored. `i_ks_key` changes mid-run have no effect.
- **Start in the cycle of `o_ks_done`:** accepted, because the FSM is already in IDLE.
- **RC width:** 5 bits. Round counter never exceeds 25 and never wraps.

## Timing
- **Reset values:** state IDLE, K=0, `o_ks_rkey`=0, `o_ks_round`=0, `o_ks_valid`=0, `o_ks_busy`=0, `o_ks_done`=0.
- **Reset mid-run:** aborts within one cycle with no `done` pulse.
- **Forward latency:** start accepted in cycle t; key 0 valid in cycle t+1.
- **Reverse latency:** key 25 valid in cycle t+26.
- **Throughput:** one key per cycle while ready is held high. A full forward run is 26 cycles of valid.
- **End of run:** `o_ks_done` is asserted the cycle after the final handshake. `o_ks_valid` is 0 in that cycle.
- **Outputs:** all outputs are registered. `o_ks_valid` does not depend combinationally on `i_ks_ready`.

## Configuration
- **`BORON_KS_REVERSE_EN` defined:**
  - `i_ks_dir` port exists.
  - PRECALC state and inverse-step logic are present.
- **Not defined:**
  - No `i_ks_dir` port, no PRECALC state, no inverse S-box.
  - Every run is forward.

## Structure
- **Package `boron_pkg`:**
  - `BORON_KEY_W`=80, `BORON_BLK_W`=64, `BORON_ROUNDS`=25, `BORON_ROT`=13.
  - S-box table {E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6} and its inverse.
  - FSM state enum.
- **Sub-module `boron_ks_step`:** combinational forward/inverse single-step function, taking K, RC and dir, and producing the next K.
  - Reuses `s_box` and `dec_s_box` for the nibble.
  - The FSM top instantiates it once.

## Test plan
- **Forward from zero:** master 80'h0, dir=0, ready=1.
  - round 0 rkey = 64'h0.
  - round 1 rkey = 64'h0800_0000_0000_000E.
  - 26 valids, then one `done` pulse.
- **Backpressure:** toggle `i_ks_ready` pseudo-randomly. The key sequence must equal the ready=1 run, with rkey stable whenever ready=0.
- **Reverse:** master 80'h0000_0000_0000_0000_000E, dir=1.
  - Valid first appears 26 cycles after start, with round=25.
  - The sequence equals the forward run reversed.
  - Last key (round 0) = 64'h0000_0000_0000_000E.
- **Reset mid-run:** assert `rst` at round 10.
  - Next cycle all outputs are 0 and there is no `done`.
  - A new start replays correctly from round 0.
- **Start while busy and back-to-back:**
  - A second start during EMIT is ignored.
  - A start in the `done` cycle begins a new run with key 0 valid the following cycle.
- **Endpoint chaining:** feed round 0 rkey into `add_round_key` and `dec_add_round_key` with plaintext 64'h7777aaaa3333eeee. The recovered plaintext must match.
